// File: rtl/mux8_scan_feeder_pkg.sv
//------------------------------------------------------------------------------
// mux8_scan_pkg : shared sizes and sequencer state encoding for mux8_scan_feeder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mux8_scan_pkg;

   localparam int NUM_WORDS = 8;
   localparam int SEL_W     = 3;
   localparam int WORD_W    = 16;

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/mux8_scan_feeder_bank.sv
//------------------------------------------------------------------------------
// reg_bank8x16 : write-decoded eight-entry register array with flat outputs
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_bank8x16
   import mux8_scan_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2,
   output logic [WIDTH-1:0] q3,
   output logic [WIDTH-1:0] q4,
   output logic [WIDTH-1:0] q5,
   output logic [WIDTH-1:0] q6,
   output logic [WIDTH-1:0] q7
);

   logic [WIDTH-1:0] mem_q [NUM_WORDS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign q0 = mem_q[0];
   assign q1 = mem_q[1];
   assign q2 = mem_q[2];
   assign q3 = mem_q[3];
   assign q4 = mem_q[4];
   assign q5 = mem_q[5];
   assign q6 = mem_q[6];
   assign q7 = mem_q[7];

endmodule

`default_nettype wire

// File: rtl/mux8_scan_feeder.sv
//------------------------------------------------------------------------------
// mux8_scan_feeder : register bank plus scan sequencer feeding an external 8:1
// mux and presenting each selected word on a valid/ready port.
// Option macro: SCAN_SKIP_ZERO_EN (zero words are skipped without a transfer).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux8_scan_feeder
   import mux8_scan_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2,
   output logic [WIDTH-1:0] q3,
   output logic [WIDTH-1:0] q4,
   output logic [WIDTH-1:0] q5,
   output logic [WIDTH-1:0] q6,
   output logic [WIDTH-1:0] q7,
   output logic [SEL_W-1:0] s,
   input  logic [WIDTH-1:0] mux_o,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   scan_state_t      state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             done_q, done_d;

   reg_bank8x16 #(
      .WIDTH (WIDTH)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .q0      (q0),
      .q1      (q1),
      .q2      (q2),
      .q3      (q3),
      .q4      (q4),
      .q5      (q5),
      .q6      (q6),
      .q7      (q7)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            sel_d = '0;
            if (start) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            // mux_o still reflects the pre-write bank, so a same-cycle write is not captured
            data_d  = mux_o;
            state_d = HOLD;
`ifdef SCAN_SKIP_ZERO_EN
            if (mux_o == '0) begin
               if (sel_q == LAST_SEL) begin
                  state_d = IDLE;
                  sel_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = FETCH;
                  sel_d   = sel_q + 3'd1;
               end
            end
`endif
         end
         HOLD: begin
            if (out_ready) begin
               if (sel_q == LAST_SEL) begin
                  state_d = IDLE;
                  sel_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = FETCH;
                  sel_d   = sel_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase
   end

   assign s         = sel_q;
   assign out_data  = data_q;
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mux8_scan_feeder.sv
//------------------------------------------------------------------------------
// tb_mux8_scan_feeder : self-checking bench with an ideal external 8:1 mux
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux8_scan_feeder;

   localparam int W = 16;

`ifdef SCAN_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, wr_en, start, out_ready;
   logic [2:0]   wr_addr;
   logic [W-1:0] wr_data;
   logic [W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
   logic [2:0]   s;
   logic [W-1:0] mux_o, out_data;
   logic         out_valid, busy, done;

   logic [W-1:0] qv [8];
   assign qv[0] = q0;
   assign qv[1] = q1;
   assign qv[2] = q2;
   assign qv[3] = q3;
   assign qv[4] = q4;
   assign qv[5] = q5;
   assign qv[6] = q6;
   assign qv[7] = q7;
   assign mux_o = qv[s];

   always #5 clk = ~clk;

   mux8_scan_feeder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .q0        (q0),
      .q1        (q1),
      .q2        (q2),
      .q3        (q3),
      .q4        (q4),
      .q5        (q5),
      .q6        (q6),
      .q7        (q7),
      .s         (s),
      .mux_o     (mux_o),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] mb [8];
   logic [W-1:0] got_q [$];

   typedef struct {
      logic [2:0]   addr;
      logic [W-1:0] data;
   } load_t;

   typedef struct {
      int           cyc;
      logic         valid;
      logic         chk_data;
      logic [W-1:0] data;
      logic [2:0]   sel;
      logic         busy;
      logic         done;
   } cyc_vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      mb[a]   = d;
   endtask

   // Cycles from start edge to the last word's completion, all readies high
   function automatic int scan_cycles();
      int n = 0;
      for (int i = 0; i < 8; i++) n += (SKIP && mb[i] == '0) ? 1 : 2;
      return n;
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_s"}, s, 0);
      chk({tag, "_data"}, out_data, 0);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_q%0d", tag, i), qv[i], 0);
   endtask

   // One full scan; transfers and done timing checked against the bank model
   task automatic scan(input int stall_cyc, input int stall_n, input logic [W-1:0] stall_data,
                       input logic [2:0] stall_s, input bit rnd, input int hz_cyc,
                       input logic [W-1:0] hz_data, input int extra_start);
      logic [W-1:0] exp_q [$];
      logic [W-1:0] g;
      int ndone = 0, dcyc = -1, stalls = 0, exp_done;
      for (int i = 0; i < 8; i++) if (!(SKIP && mb[i] == '0)) exp_q.push_back(mb[i]);
      exp_done = 1 + scan_cycles();
      got_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("scan_busy_c1", busy, 1);
      chk("scan_valid_c1", out_valid, 0);
      for (int c = 1; c < 300; c++) begin
         if (done) begin
            ndone++;
            if (dcyc < 0) begin
               dcyc = c;
               chk("done_busy", busy, 0);
            end
         end
         if (dcyc >= 0 && c >= dcyc + 25) break;
         wr_en = 1'b0;
         start = 1'b0;
         if (c == hz_cyc) begin
            chk("hz_s", s, 3);
            chk("hz_fetch", out_valid, 0);
            wr_en   = 1'b1;
            wr_addr = 3'd3;
            wr_data = hz_data;
            mb[3]   = hz_data;
         end
         if (c == extra_start) start = 1'b1;
         if (rnd) begin
            out_ready = 1'($urandom_range(0, 1));
         end else if (c >= stall_cyc && c < stall_cyc + stall_n) begin
            out_ready = 1'b0;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, stall_data);
            chk("bp_s", s, stall_s);
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && !out_ready) stalls++;
         if (out_valid && out_ready) got_q.push_back(out_data);
         tick();
      end
      wr_en     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      chk("done_count", ndone, 1);
      chk("done_cycle", dcyc, exp_done + stalls);
      chk("xfer_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         chk($sformatf("xfer%0d", i), g, exp_q[i]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      load_t    loads [8];
      cyc_vec_t vec [17];
      logic [W-1:0] g;
      int       dn;

      loads = '{'{3'd0, 16'd6234}, '{3'd1, 16'd725}, '{3'd2, 16'd7524}, '{3'd3, 16'd5734},
                '{3'd4, 16'd8354}, '{3'd5, 16'd28457}, '{3'd6, 16'd2458}, '{3'd7, 16'd2547}};
      for (int k = 0; k < 17; k++) begin
         vec[k].cyc      = k + 1;
         vec[k].valid    = (vec[k].cyc % 2 == 0) && (vec[k].cyc <= 16);
         vec[k].chk_data = vec[k].valid;
         vec[k].data     = vec[k].valid ? loads[(vec[k].cyc - 2) / 2].data : '0;
         vec[k].sel      = (vec[k].cyc <= 16) ? 3'((vec[k].cyc - 1) / 2) : 3'd0;
         vec[k].busy     = (vec[k].cyc <= 16);
         vec[k].done     = (vec[k].cyc == 17);
      end

      rst = 1'b1; wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
      wr_addr = '0; wr_data = '0;
      for (int i = 0; i < 8; i++) mb[i] = '0;
      repeat (2) tick();
      check_reset_state("rst");
      rst = 1'b0;
      tick();

      // Reference scan, per-cycle table
      for (int i = 0; i < 8; i++) wr(loads[i].addr, loads[i].data);
      for (int i = 0; i < 8; i++) chk($sformatf("load_q%0d", i), qv[i], mb[i]);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 17; k++) begin
         chk($sformatf("t1_valid_c%0d", vec[k].cyc), out_valid, vec[k].valid);
         if (vec[k].chk_data) chk($sformatf("t1_data_c%0d", vec[k].cyc), out_data, vec[k].data);
         chk($sformatf("t1_s_c%0d", vec[k].cyc), s, vec[k].sel);
         chk($sformatf("t1_busy_c%0d", vec[k].cyc), busy, vec[k].busy);
         chk($sformatf("t1_done_c%0d", vec[k].cyc), done, vec[k].done);
         tick();
      end

      // Backpressure at word 3 for five cycles
      scan(8, 5, 16'd5734, 3'd3, 1'b0, -1, '0, -1);

      // Write to the entry being fetched
      scan(-1, 0, '0, '0, 1'b0, 7, 16'd9353, -1);
      chk("hz_old_carried", mb[3], 16'd9353);
      scan(-1, 0, '0, '0, 1'b0, -1, '0, -1);
      g = (got_q.size() > 3) ? got_q[3] : 'x;
      chk("hz_new_value", g, 16'd9353);

      // Start pulse while busy
      scan(-1, 0, '0, '0, 1'b0, -1, '0, 3);

      // Reset during HOLD at word 5
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();
      chk("rh_valid", out_valid, 1);
      chk("rh_s", s, 5);
      rst = 1'b1;
      out_ready = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mb[i] = '0;
      check_reset_state("rh");
      out_ready = 1'b1;
      dn = 0;
      repeat (20) begin
         tick();
         if (done) dn++;
      end
      chk("rh_no_done", dn, 0);

      // Single nonzero word
      wr(1, 16'd65535);
      scan(-1, 0, '0, '0, 1'b0, -1, '0, -1);

      // Random banks with random backpressure and stray starts
      repeat (15) begin
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) wr(i, '0);
            else wr(i, W'($urandom));
         end
         scan(-1, 0, '0, '0, 1'b1, -1, '0, int'($urandom_range(2, 10)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mux8_scan_feeder.md
# mux8_scan_feeder

Eight-entry, 16-bit register bank with a scan sequencer that sits directly upstream of the 8:1 16-bit multiplexer stage. It holds the eight data words on `q0`–`q7` and steps the 3-bit select `s` from 0 to 7. It samples the multiplexer's output `mux_o` and presents each selected word on a valid/ready output port. Software loads words through a simple write port and launches one full scan with a `start` pulse.

## Interface
Parameters:
- `WIDTH`, 16: data word width; all word ports and registers use this width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe into the bank.
- `wr_addr` in 3: bank entry to write.
- `wr_data` in WIDTH: write data.
- `start` in 1: launch a scan; sampled only in IDLE.
- `q0`..`q7` out WIDTH each: bank contents, driven to mux inputs i0..i7.
- `s` out 3: mux select.
- `mux_o` in WIDTH: mux output returned to this block.
- `out_data` out WIDTH: captured word.
- `out_valid` out 1: `out_data` holds a word.
- `out_ready` in 1: consumer accepts.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse after the last word completes.

## Operation
- Reset: `q0`–`q7` = 0, `s` = 0, `out_data` = 0, `out_valid` = 0, `busy` = 0, `done` = 0, state = IDLE.
- Bank write:
  - On `wr_en`, `q[wr_addr]` takes `wr_data` at the edge.
  - The new value is visible the next cycle.
  - Writes are allowed in every state.
- States:
  - IDLE: `s` = 0. `start` moves the block to FETCH.
  - FETCH: `s` holds the current index. At the edge, `out_data` <= `mux_o`, then go to HOLD.
  - HOLD: `out_valid` = 1 and `out_data` is stable.
    - On `out_valid & out_ready`: if `s` = 7, go to IDLE with `done` = 1 and `s` = 0.
    - Otherwise `s` increments and the block returns to FETCH.
- `start` is ignored while `busy` is high. It is not queued.
- Write hazard in FETCH: a write to `q[s]` in the same FETCH cycle is not captured. The captured value is the pre-write content. A write in HOLD does not change `out_data`.
- `s` never wraps past 7 during a scan. It is 0 whenever the block is IDLE.
- `rst` in any state aborts the scan and restores reset values immediately at that edge. No `done` is produced.

## Timing
- `start` sampled at edge E0 → FETCH with `s` = 0 in cycle 1 → `out_valid` high in cycle 2.
- Each word takes at least 2 cycles (FETCH + HOLD).
- With `out_ready` tied high:
  - Word k is valid in cycle 2k+2.
  - Last word is valid in cycle 16.
  - `done` = 1 and `busy` = 0 in cycle 17.
- Backpressure: HOLD persists while `out_ready` = 0. `out_data` and `s` must not change during that time.
- `busy` is high from cycle 1 through the cycle `done` is asserted, exclusive of that cycle.
- The `mux_o` path is combinational from `s` and `q*`. It must settle within one cycle.

## Configuration
- `SCAN_SKIP_ZERO_EN` defined:
  - In FETCH, if `mux_o` == 0, the block skips HOLD and `out_valid` stays low.
  - `s` advances directly, or the block goes to IDLE with `done` if `s` = 7. That costs one cycle per skipped word.
  - A bank of all zeros gives `done` in cycle 9 with no transfers.
- Undefined: every word is presented, including zeros.

## Structure
- Package `mux8_scan_pkg`:
  - Constants `NUM_WORDS` = 8, `SEL_W` = 3, `WORD_W` = 16.
  - State enum {IDLE, FETCH, HOLD}.
- Sub-module `reg_bank8x16`: the write-decoded 8-entry register array with flat `q0`–`q7` outputs.
- The sequencer FSM, capture register and handshake live in the top module.

## Test plan
- Load 6234, 725, 7524, 5734, 8354, 28457, 2458, 2547 into entries 0–7, pulse `start`, tie `out_ready` = 1:
  - Eight transfers in that order in cycles 2, 4, …, 16.
  - `done` in cycle 17.
- Same scan with `out_ready` low for 5 cycles at word 3:
  - `out_data` = 5734 and `s` = 3 stay stable throughout.
  - The scan resumes with no loss or duplication.
- Write 9353 to entry 3 during the FETCH with `s` = 3 (old value 5734):
  - The transfer carries 5734.
  - A later scan carries 9353.
- Assert `rst` while in HOLD at word 5:
  - Next cycle `out_valid` = 0, `s` = 0, `busy` = 0, all `q` = 0, no `done`.
- Pulse `start` while `busy`:
  - Ignored, with exactly one `done` per scan.
  - With `SCAN_SKIP_ZERO_EN` and entries {0, 65535, 0, 0, 0, 0, 0, 0}, exactly one transfer (65535) and `done` in cycle 10.
